dffram_wb_ctrl: RTL and testbench

Wishbone slave controller sitting directly upstream of the 256×32 DFFRAM macro. Decodes a word-aligned Wishbone B4 classic request, drives the RAM's EN/WE/A/Di pins, captures the one-cycle-latency Do, and returns ACK or ERR. Optionally zero-fills the whole RAM after reset before accepting traffic.

---
 rtl/dffram_wb_pkg.sv | 22 ++
 rtl/dffram_clear_seq.sv | 47 ++++
 rtl/dffram_wb_ctrl.sv | 144 ++++++++++++++
 tb/tb_dffram_wb_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dffram_wb_pkg.sv
// Shared types and address-slice constants for the DFFRAM Wishbone controller.
// Used by dffram_wb_ctrl and dffram_clear_seq.
package dffram_wb_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam int DFFRAM_WORDS = 256;
   localparam int WORD_LSB     = 2;
   localparam int WORD_MSB     = 9;
   localparam int BASE_LSB     = 10;
   localparam int BASE_MSB     = 31;

   // Region match on the upper bits plus word alignment.
   function automatic logic addr_hit(input logic [31:0] adr, input logic [31:0] base);
      return (adr[BASE_MSB:BASE_LSB] == base[BASE_MSB:BASE_LSB]) && (adr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/dffram_clear_seq.sv
// Post-reset zero-fill sequencer: writes 0 to every RAM word, one per cycle.
// Only instantiated when DFFRAM_WB_CLEAR_EN is defined.
module dffram_clear_seq
   import dffram_wb_pkg::*;
#(
   parameter int WORDS = DFFRAM_WORDS
)
(
   input  logic        CLK,
   input  logic        RESETn,
   output logic        clr_en,
   output logic [3:0]  clr_we,
   output logic [7:0]  clr_a,
   output logic [31:0] clr_di,
   output logic        clr_last,
   output logic        init_done
);

   logic [7:0] cnt_r;
   logic       done_r;

   // The RESETn gate keeps the RAM idle while reset is held.
   assign clr_en    = ~done_r & RESETn;
   assign clr_we    = clr_en ? 4'hF : 4'h0;
   assign clr_a     = cnt_r;
   assign clr_di    = 32'h0000_0000;
   assign clr_last  = clr_en & (cnt_r == 8'(WORDS - 1));
   assign init_done = done_r;

   // Address counter and completion flag.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cnt_r  <= 8'h00;
         done_r <= 1'b0;
      end else if (clr_last) begin
         cnt_r  <= 8'h00;
         done_r <= 1'b1;
      end else if (clr_en) begin
         cnt_r  <= cnt_r + 8'h01;
         done_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_r;
         done_r <= done_r;
      end
   end

endmodule

// File: rtl/dffram_wb_ctrl.sv
// Wishbone B4 classic slave in front of a 256x32 DFFRAM (1-cycle read latency).
// Define DFFRAM_WB_CLEAR_EN to zero-fill the RAM after reset before serving traffic.
module dffram_wb_ctrl
   import dffram_wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          WORDS     = DFFRAM_WORDS
)
(
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   output logic        wbs_ack_o,
   output logic        wbs_err_o,
   output logic        ram_en,
   output logic [3:0]  ram_we,
   output logic [7:0]  ram_a,
   output logic [31:0] ram_di,
   input  logic [31:0] ram_do,
   output logic        init_done
);

   state_t      state_r;
   logic        ack_r;
   logic        err_r;
   logic        rd_r;
   logic        req_s;
   logic        hit_s;
   logic        clr_en_s;
   logic [3:0]  clr_we_s;
   logic [7:0]  clr_a_s;
   logic [31:0] clr_di_s;
   logic        clr_last_s;

`ifdef DFFRAM_WB_CLEAR_EN
   localparam state_t RESET_STATE = ST_CLEAR;

   dffram_clear_seq #(
      .WORDS     (WORDS)
   ) u_clear (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .clr_en    (clr_en_s),
      .clr_we    (clr_we_s),
      .clr_a     (clr_a_s),
      .clr_di    (clr_di_s),
      .clr_last  (clr_last_s),
      .init_done (init_done)
   );
`else
   localparam state_t RESET_STATE = ST_IDLE;

   assign clr_en_s   = 1'b0;
   assign clr_we_s   = 4'h0;
   assign clr_a_s    = 8'h00;
   assign clr_di_s   = 32'h0000_0000;
   assign clr_last_s = 1'b0;
   assign init_done  = 1'b1;
`endif

   // RESETn in the request term keeps the RAM pins quiet while reset is asserted.
   assign req_s = wbs_cyc_i & wbs_stb_i & (state_r == ST_IDLE) & RESETn;
   assign hit_s = addr_hit(wbs_adr_i, BASE_ADDR) &&
                  (32'(wbs_adr_i[WORD_MSB:WORD_LSB]) < 32'(WORDS));

   assign wbs_ack_o = ack_r;
   assign wbs_err_o = err_r;
   assign wbs_dat_o = (ack_r & rd_r) ? ram_do : 32'h0000_0000;

   // Controller FSM with registered ACK/ERR and read-pending flag.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_r <= RESET_STATE;
         ack_r   <= 1'b0;
         err_r   <= 1'b0;
         rd_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_CLEAR: begin
               ack_r   <= 1'b0;
               err_r   <= 1'b0;
               rd_r    <= 1'b0;
               state_r <= clr_last_s ? ST_IDLE : ST_CLEAR;
            end
            ST_IDLE: begin
               if (req_s) begin
                  ack_r   <= hit_s;
                  err_r   <= ~hit_s;
                  rd_r    <= hit_s & ~wbs_we_i;
                  state_r <= ST_RESP;
               end else begin
                  ack_r   <= 1'b0;
                  err_r   <= 1'b0;
                  rd_r    <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_RESP: begin
               ack_r   <= 1'b0;
               err_r   <= 1'b0;
               rd_r    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               ack_r   <= 1'b0;
               err_r   <= 1'b0;
               rd_r    <= 1'b0;
               state_r <= RESET_STATE;
            end
         endcase
      end
   end

   // RAM pin drive: bus access in IDLE, zero-fill in CLEAR, idle otherwise.
   always_comb begin
      ram_en = 1'b0;
      ram_we = 4'h0;
      ram_a  = 8'h00;
      ram_di = 32'h0000_0000;
      if (req_s && hit_s) begin
         ram_en = 1'b1;
         ram_we = wbs_we_i ? wbs_sel_i : 4'h0;
         ram_a  = wbs_adr_i[WORD_MSB:WORD_LSB];
         ram_di = wbs_dat_i;
      end else if (state_r == ST_CLEAR) begin
         ram_en = clr_en_s;
         ram_we = clr_we_s;
         ram_a  = clr_a_s;
         ram_di = clr_di_s;
      end else begin
         ram_en = 1'b0;
         ram_we = 4'h0;
         ram_a  = 8'h00;
         ram_di = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_dffram_wb_ctrl.sv
// Directed scoreboard bench for dffram_wb_ctrl with a behavioural DFFRAM model.
// Adds the zero-fill scenario when DFFRAM_WB_CLEAR_EN is defined.
module tb_dffram_wb_ctrl;

   typedef struct packed {
      logic        ack;
      logic        err;
      logic [31:0] dat;
   } rsp_t;

   logic        CLK;
   logic        RESETn;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;
   logic        wbs_err_o;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [7:0]  ram_a;
   logic [31:0] ram_di;
   logic [31:0] ram_do;
   logic        init_done;

   logic [31:0] mem [0:255];
   rsp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;

`ifdef DFFRAM_WB_CLEAR_EN
   localparam logic CLEAR_BUILD = 1'b1;
`else
   localparam logic CLEAR_BUILD = 1'b0;
`endif

   dffram_wb_ctrl dut (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_dat_o (wbs_dat_o),
      .wbs_ack_o (wbs_ack_o),
      .wbs_err_o (wbs_err_o),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_a     (ram_a),
      .ram_di    (ram_di),
      .ram_do    (ram_do),
      .init_done (init_done)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // DFFRAM model: byte-enabled write, registered read.
   always @(posedge CLK) begin
      if (ram_en) begin
         ram_do <= mem[ram_a];
         for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_and_check(input string tag);
      rsp_t e;
      if (sb_q.size() == 0) begin
         chk({tag, ":sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk({tag, ":ack"}, 32'(wbs_ack_o), 32'(e.ack));
         chk({tag, ":err"}, 32'(wbs_err_o), 32'(e.err));
         chk({tag, ":dat"}, wbs_dat_o, e.dat);
      end
   endtask

   task automatic wait_rsp(output int cycles);
      cycles = 0;
      do begin
         @(negedge CLK);
         cycles++;
      end while (!(wbs_ack_o | wbs_err_o) && cycles < 400);
      if (!(wbs_ack_o | wbs_err_o)) chk("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_init();
      int n;
      n = 0;
      while (!init_done && n < 400) begin
         @(negedge CLK);
         n++;
      end
      chk("init_done", 32'(init_done), 32'd1);
   endtask

   task automatic xfer(input string tag, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat,
                       input logic hit, input logic [31:0] rdat);
      rsp_t e;
      int   cyc_n;
      @(negedge CLK);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_sel_i = sel;
      wbs_adr_i = adr;
      wbs_dat_i = dat;
      e.ack = hit;
      e.err = ~hit;
      e.dat = (hit && !we) ? rdat : 32'h0;
      sb_q.push_back(e);
      #1;
      chk({tag, ":ram_en"}, 32'(ram_en), 32'(hit));
      if (hit) begin
         chk({tag, ":ram_a"}, 32'(ram_a), 32'(adr[9:2]));
         chk({tag, ":ram_we"}, 32'(ram_we), we ? 32'(sel) : 32'd0);
         chk({tag, ":ram_di"}, ram_di, dat);
      end
      wait_rsp(cyc_n);
      chk({tag, ":latency"}, 32'(cyc_n), 32'd1);
      chk({tag, ":resp_en"}, 32'(ram_en), 32'd0);
      pop_and_check(tag);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      @(negedge CLK);
      chk({tag, ":ack_1cyc"}, 32'(wbs_ack_o | wbs_err_o), 32'd0);
   endtask

   initial begin
      logic [31:0] b2b_adr [4];
      logic [31:0] b2b_dat [4];
      rsp_t        e;
      int          cyc_n;

      RESETn    = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'h0;
      wbs_adr_i = 32'h0;
      wbs_dat_i = 32'h0;

      #3;
      chk("rst:ack", 32'(wbs_ack_o), 32'd0);
      chk("rst:err", 32'(wbs_err_o), 32'd0);
      chk("rst:dat", wbs_dat_o, 32'd0);
      chk("rst:ram_en", 32'(ram_en), 32'd0);
      chk("rst:ram_we", 32'(ram_we), 32'd0);
      chk("rst:ram_a", 32'(ram_a), 32'd0);
      chk("rst:ram_di", ram_di, 32'd0);
      chk("rst:init_done", 32'(init_done), CLEAR_BUILD ? 32'd0 : 32'd1);
      repeat (2) @(negedge CLK);
      RESETn = 1'b1;
      if (CLEAR_BUILD) wait_init();

      // Full write then read, plus a sel==0 write that must leave data intact.
      xfer("wr10", 1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0);
      xfer("rd10", 1'b0, 4'hF, 32'h3000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF);
      xfer("wr10_sel0", 1'b1, 4'h0, 32'h3000_0010, 32'h0, 1'b1, 32'h0);
      xfer("rd10_again", 1'b0, 4'hF, 32'h3000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF);

      // Byte-lane write at the top word.
      xfer("wr3fc", 1'b1, 4'hF, 32'h3000_03FC, 32'h1122_3344, 1'b1, 32'h0);
      xfer("wr3fc_b1", 1'b1, 4'b0010, 32'h3000_03FC, 32'h0000_AA00, 1'b1, 32'h0);
      xfer("rd3fc", 1'b0, 4'hF, 32'h3000_03FC, 32'h0, 1'b1, 32'h1122_AA44);

      // Decode errors.
      xfer("misalign", 1'b0, 4'hF, 32'h3000_0002, 32'h0, 1'b0, 32'h0);
      xfer("offbase", 1'b0, 4'hF, 32'h4000_0000, 32'h0, 1'b0, 32'h0);

      // Back-to-back reads with stb held high.
      b2b_adr[0] = 32'h3000_0010; b2b_dat[0] = 32'hDEAD_BEEF;
      b2b_adr[1] = 32'h3000_03FC; b2b_dat[1] = 32'h1122_AA44;
      b2b_adr[2] = 32'h3000_0010; b2b_dat[2] = 32'hDEAD_BEEF;
      b2b_adr[3] = 32'h3000_03FC; b2b_dat[3] = 32'h1122_AA44;
      @(negedge CLK);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'hF;
      wbs_adr_i = b2b_adr[0];
      e = '{ack: 1'b1, err: 1'b0, dat: b2b_dat[0]};
      sb_q.push_back(e);
      for (int i = 0; i < 4; i++) begin
         wait_rsp(cyc_n);
         chk($sformatf("b2b%0d:latency", i), 32'(cyc_n), (i == 0) ? 32'd1 : 32'd2);
         pop_and_check($sformatf("b2b%0d", i));
         if (i < 3) begin
            wbs_adr_i = b2b_adr[i + 1];
            e = '{ack: 1'b1, err: 1'b0, dat: b2b_dat[i + 1]};
            sb_q.push_back(e);
         end
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      @(negedge CLK);
      chk("b2b:idle", 32'(wbs_ack_o), 32'd0);

      // Reset asserted while a read response is on the bus.
      @(negedge CLK);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_adr_i = 32'h3000_0010;
      e = '{ack: 1'b1, err: 1'b0, dat: 32'hDEAD_BEEF};
      sb_q.push_back(e);
      wait_rsp(cyc_n);
      chk("midrst:pre_dat", wbs_dat_o, 32'hDEAD_BEEF);
      RESETn = 1'b0;
      #1;
      chk("midrst:ack", 32'(wbs_ack_o), 32'd0);
      chk("midrst:err", 32'(wbs_err_o), 32'd0);
      chk("midrst:dat", wbs_dat_o, 32'd0);
      chk("midrst:ram_en", 32'(ram_en), 32'd0);
      void'(sb_q.pop_front());
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      repeat (2) @(negedge CLK);
      RESETn = 1'b1;
      if (CLEAR_BUILD) wait_init();
      xfer("postrst_rd", 1'b0, 4'hF, 32'h3000_0010, 32'h0, 1'b1,
           CLEAR_BUILD ? 32'h0 : 32'hDEAD_BEEF);

`ifdef DFFRAM_WB_CLEAR_EN
      // Preloaded RAM, reset, strobe right at release: stall for the whole fill.
      for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
      @(negedge CLK);
      RESETn = 1'b0;
      repeat (2) @(negedge CLK);
      RESETn    = 1'b1;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_adr_i = 32'h3000_0010;
      e = '{ack: 1'b1, err: 1'b0, dat: 32'h0};
      sb_q.push_back(e);
      #1;
      chk("clr:init_low", 32'(init_done), 32'd0);
      wait_rsp(cyc_n);
      chk("clr:stall", 32'(cyc_n), 32'd257);
      chk("clr:init_high", 32'(init_done), 32'd1);
      pop_and_check("clr_rd10");
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      @(negedge CLK);
      xfer("clr_rd0", 1'b0, 4'hF, 32'h3000_0000, 32'h0, 1'b1, 32'h0);
      xfer("clr_rd3fc", 1'b0, 4'hF, 32'h3000_03FC, 32'h0, 1'b1, 32'h0);
      xfer("clr_rd200", 1'b0, 4'hF, 32'h3000_0200, 32'h0, 1'b1, 32'h0);
`endif

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
